// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: multi-cycle RV32 decode/issue FSM driving ALU, regfile reads, writeback and BEQ resolution
module alu_issue_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter bit SUPPRESS_X0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              alu_enable,
  output logic [4:0]        alu_command,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              branch_valid,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_offset,
  output logic              illegal
);
  typedef enum logic [2:0] {IDLE, DECODE, SETUP, EXEC, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic [31:0] ir;
  logic [2:0] f3;
  logic [6:0] f7, op;
  logic r_op, i_op, b_op, r_ok, legal, rd0;
  logic [4:0] cmd;
  logic [DATA_W-1:0] d2, off;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign rs1_addr = REG_AW'(ir[19:15]);
  assign rs2_addr = REG_AW'(ir[24:20]);
  assign instr_ready = (state == IDLE) & ~rst;
  assign r_op = op == 7'b0110011;
  assign i_op = op == 7'b0010011 && f3 == 3'b000;
  assign b_op = op == 7'b1100011 && f3 == 3'b000;
  assign r_ok = r_op && ((f7 == 7'b0000000 && f3 inside {3'b000, 3'b001, 3'b100, 3'b110, 3'b111}) ||
                         (f7 == 7'b0100000 && f3 == 3'b000));
  assign legal = r_ok | i_op | b_op;
  assign rd0 = ir[11:7] == 5'd0;
  // command is only meaningful for legal encodings; the last arm is AND
  assign cmd = (b_op || (r_op && f3 == 3'b000 && f7[5])) ? 5'b00001 :
               (i_op || f3 == 3'b000)                    ? 5'b00010 :
               f3 == 3'b001                              ? 5'b00100 :
               f3 == 3'b100                              ? 5'b01000 :
               f3 == 3'b110                              ? 5'b10000 : 5'b00111;
  assign d2 = i_op                     ? {{(DATA_W-12){ir[31]}}, ir[31:20]} :
              (r_op && f3 == 3'b001)   ? {{(DATA_W-5){1'b0}}, rs2_data[4:0]} : rs2_data;
  assign off = {{(DATA_W-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = instr_valid ? DECODE : IDLE;
      DECODE:  state_n = legal ? SETUP : DONE;
      SETUP:   state_n = EXEC;
      EXEC:    state_n = CAPTURE;
      CAPTURE: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ir <= '0;
      alu_enable <= 1'b0;
      alu_command <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      wb_en <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
      branch_offset <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && instr_valid) ir <= instr;
      // operands registered on leaving DECODE so the ALU sees them a full cycle before its enable
      if (state == DECODE && legal) begin
        alu_command <= cmd;
        alu_data1 <= rs1_data;
        alu_data2 <= d2;
      end
      alu_enable <= state == SETUP;
      illegal <= state == DECODE && !legal;
      wb_en <= state == CAPTURE && !b_op && !(SUPPRESS_X0 && rd0);
      branch_valid <= state == CAPTURE && b_op;
      if (state == CAPTURE) begin
        wb_data <= alu_result;
        wb_addr <= REG_AW'(ir[11:7]);
        branch_taken <= alu_zero;
        branch_offset <= off;
      end
    end
  end
endmodule
